complex_alu_sched: RTL and testbench

Two-requester scheduler that shares one complex ALU (16-bit operands, 48-bit result, 2-bit operation code) between two clients. It arbitrates round-robin, captures operands, sequences the ALU `start`/`valid` handshake, and routes the result or error back to the winning client. It sits between client logic and the ALU instance and is the only driver of the ALU control inputs.

---
 rtl/complex_alu_sched.sv | 235 +++++++++++++++++++++++
 tb/tb_complex_alu_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_alu_sched.sv
// complex_alu_sched: round-robin scheduler sharing one complex ALU
// between two clients; optional watchdog under COMPLEX_ALU_SCHED_TIMEOUT_EN.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req*/op*/m1_*/m2_*    client requests, op codes and operands
//   ack*/done*/err*       per-client one-cycle handshake pulses
//   rsp_result            shared result bus, qualified by done*
//   busy/grant_id/timeout status
//   alu_*                 ALU control, operands and response
module complex_alu_sched #(
  parameter int W_IN    = 16,
  parameter int W_RES   = 48,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [W_IN-1:0]  m1_0,
  input  logic [W_IN-1:0]  m2_0,
  input  logic [W_IN-1:0]  m1_1,
  input  logic [W_IN-1:0]  m2_1,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic             err0,
  output logic             err1,
  output logic [W_RES-1:0] rsp_result,
  output logic             busy,
  output logic             grant_id,
  output logic             timeout,
  output logic             alu_start,
  output logic             alu_a_valid,
  output logic             alu_b_valid,
  output logic [1:0]       alu_operation,
  output logic [W_IN-1:0]  alu_m1,
  output logic [W_IN-1:0]  alu_m2,
  input  logic             alu_valid,
  input  logic             alu_error,
  input  logic [W_RES-1:0] alu_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             gid_q, gid_d;
  logic             ill_q, ill_d;
  logic             start_q, start_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             err0_q, err0_d;
  logic             err1_q, err1_d;
  logic [1:0]       op_q, op_d;
  logic [W_IN-1:0]  m1_q, m1_d;
  logic [W_IN-1:0]  m2_q, m2_d;
  logic [W_RES-1:0] res_q, res_d;
  logic             win, rsp;
  logic             done_p, err_p;
  logic [1:0]       op_w;

`ifdef COMPLEX_ALU_SCHED_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
  logic [7:0] cnt_q, cnt_d;
  logic       to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    ill_d   = ill_q;
    start_d = start_q;
    op_d    = op_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    res_d   = res_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    done_p  = 1'b0;
    err_p   = 1'b0;
`ifdef COMPLEX_ALU_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    rsp  = alu_valid | alu_error;
    // tie goes to the client not served last
    win  = (req0 & req1) ? ~last_q : req1;
    op_w = win ? op1 : op0;

    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          ack0_d = ~win;
          ack1_d = win;
          last_d = win;
          gid_d  = win;
          op_d   = op_w;
          m1_d   = win ? m1_1 : m1_0;
          m2_d   = win ? m2_1 : m2_0;
          if (op_w == 2'd3) begin
            // illegal op: skip the ALU, error leaves from RESP
            ill_d   = 1'b1;
            state_d = RESP;
          end else begin
            start_d = 1'b1;
            state_d = ISSUE;
`ifdef COMPLEX_ALU_SCHED_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ISSUE, WAIT: begin
        if (rsp) begin
          state_d = RESP;
          start_d = 1'b0;
          if (alu_error) begin
            err_p = 1'b1;
            res_d = '0;
          end else begin
            done_p = 1'b1;
            res_d  = alu_result;
          end
        end
`ifdef COMPLEX_ALU_SCHED_TIMEOUT_EN
        else if (cnt_q + 8'd1 == TO_LIM) begin
          state_d = RESP;
          start_d = 1'b0;
          err_p   = 1'b1;
          to_d    = 1'b1;
          res_d   = '0;
        end
`endif
        else begin
          state_d = WAIT;
`ifdef COMPLEX_ALU_SCHED_TIMEOUT_EN
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
        if (ill_q) begin
          ill_d = 1'b0;
          err_p = 1'b1;
          res_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    done0_d = done_p & ~gid_q;
    done1_d = done_p & gid_q;
    err0_d  = err_p & ~gid_q;
    err1_d  = err_p & gid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      ill_q   <= 1'b0;
      start_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      op_q    <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
      res_q   <= '0;
`ifdef COMPLEX_ALU_SCHED_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      ill_q   <= ill_d;
      start_q <= start_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      op_q    <= op_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      res_q   <= res_d;
`ifdef COMPLEX_ALU_SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign ack0          = ack0_q;
  assign ack1          = ack1_q;
  assign done0         = done0_q;
  assign done1         = done1_q;
  assign err0          = err0_q;
  assign err1          = err1_q;
  assign rsp_result    = res_q;
  assign busy          = (state_q != IDLE);
  assign grant_id      = gid_q;
  assign alu_start     = start_q;
  assign alu_a_valid   = start_q;
  assign alu_b_valid   = start_q;
  assign alu_operation = op_q;
  assign alu_m1        = m1_q;
  assign alu_m2        = m2_q;
`ifdef COMPLEX_ALU_SCHED_TIMEOUT_EN
  assign timeout       = to_q;
`else
  assign timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_complex_alu_sched.sv
// tb_complex_alu_sched: directed bench for complex_alu_sched
// with a behavioural ALU that answers a set number of cycles after start.
module tb_complex_alu_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [1:0]  op0, op1;
  logic [15:0] m1_0, m2_0, m1_1, m2_1;
  logic        ack0, ack1, done0, done1, err0, err1;
  logic [47:0] rsp_result;
  logic        busy, grant_id, timeout;
  logic        alu_start, alu_a_valid, alu_b_valid;
  logic [1:0]  alu_operation;
  logic [15:0] alu_m1, alu_m2;
  logic        alu_valid, alu_error;
  logic [47:0] alu_result;

  int n_cmp = 0;
  int n_bad = 0;

  int          mdl_lat   = 2;
  logic        mdl_v     = 1'b1;
  logic        mdl_e     = 1'b0;
  logic        mdl_never = 1'b0;
  logic        mdl_mul   = 1'b0;
  logic [47:0] mdl_res   = '0;
  int          mdl_cnt   = 0;

  always #5 clk = ~clk;

  complex_alu_sched #(.W_IN(16), .W_RES(48), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .m1_0(m1_0), .m2_0(m2_0), .m1_1(m1_1), .m2_1(m2_1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rsp_result(rsp_result),
    .busy(busy), .grant_id(grant_id), .timeout(timeout),
    .alu_start(alu_start), .alu_a_valid(alu_a_valid),
    .alu_b_valid(alu_b_valid), .alu_operation(alu_operation),
    .alu_m1(alu_m1), .alu_m2(alu_m2),
    .alu_valid(alu_valid), .alu_error(alu_error),
    .alu_result(alu_result)
  );

  // ALU model: strobe on the mdl_lat-th cycle of alu_start
  always @(negedge clk) begin
    if (!alu_start) begin
      mdl_cnt   = 0;
      alu_valid = 1'b0;
      alu_error = 1'b0;
    end else begin
      mdl_cnt = mdl_cnt + 1;
      if (mdl_cnt == mdl_lat && !mdl_never) begin
        alu_valid  = mdl_v;
        alu_error  = mdl_e;
        alu_result = mdl_mul ? {16'h0, 32'(alu_m1) * 32'(alu_m2)}
                             : mdl_res;
      end else begin
        alu_valid = 1'b0;
        alu_error = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ack(output int k);
    k = 0;
    do begin tick(); k++; end while (!(ack0 | ack1) && k < 20);
    chk("ack_seen", 64'(ack0 | ack1), 64'd1);
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    while (!(done0 | done1 | err0 | err1) && k < 40) begin
      tick(); k++;
    end
    chk("rsp_seen", 64'(done0 | done1 | err0 | err1), 64'd1);
  endtask

  typedef struct {
    logic r0, r1;
    logic [1:0] o0, o1;
    logic [15:0] a0, b0, a1, b1;
    int lat;
    logic v, e;
    logic [47:0] res;
    logic gid;
    logic dn;
    logic [47:0] xres;
  } vec_t;

  vec_t tv[7];

  task automatic run_row(input int idx, input vec_t v);
    int   k;
    logic ill, saw;
    logic [3:0] xf;
    ill = ((v.gid ? v.o1 : v.o0) == 2'd3);
    mdl_lat = v.lat; mdl_v = v.v; mdl_e = v.e;
    mdl_res = v.res; mdl_never = 1'b0; mdl_mul = 1'b0;
    op0 = v.o0; op1 = v.o1;
    m1_0 = v.a0; m2_0 = v.b0; m1_1 = v.a1; m2_1 = v.b1;
    req0 = v.r0; req1 = v.r1;
    wait_ack(k);
    chk($sformatf("r%0d_ack_client", idx), 64'({ack1, ack0}),
        v.gid ? 64'd2 : 64'd1);
    chk($sformatf("r%0d_grant_id", idx), 64'(grant_id), 64'(v.gid));
    chk($sformatf("r%0d_start", idx), 64'(alu_start), 64'(!ill));
    if (!ill) begin
      chk($sformatf("r%0d_alu_m1", idx), 64'(alu_m1),
          64'(v.gid ? v.a1 : v.a0));
      chk($sformatf("r%0d_alu_m2", idx), 64'(alu_m2),
          64'(v.gid ? v.b1 : v.b0));
      chk($sformatf("r%0d_alu_op", idx), 64'(alu_operation),
          64'(v.gid ? v.o1 : v.o0));
    end
    req0 = 1'b0; req1 = 1'b0;
    saw = alu_start;
    k = 0;
    while (!(done0 | done1 | err0 | err1) && k < 40) begin
      tick(); k++;
      saw = saw | alu_start;
    end
    xf = v.dn ? (v.gid ? 4'b1000 : 4'b0100)
              : (v.gid ? 4'b0010 : 4'b0001);
    chk($sformatf("r%0d_flags", idx),
        64'({done1, done0, err1, err0}), 64'(xf));
    chk($sformatf("r%0d_result", idx), 64'(rsp_result), 64'(v.xres));
    if (ill) begin
      chk($sformatf("r%0d_ill_start", idx), 64'(saw), 64'd0);
      chk($sformatf("r%0d_ill_lat", idx), 64'(k), 64'd1);
    end
    tick();
    chk($sformatf("r%0d_idle", idx), 64'(busy), 64'd0);
  endtask

  initial begin
    int k;
    req0 = 0; req1 = 0; op0 = 0; op1 = 0;
    m1_0 = 0; m2_0 = 0; m1_1 = 0; m2_1 = 0;
    alu_valid = 0; alu_error = 0; alu_result = '0;

    tv[0] = '{1,0, 2'd0,2'd0, 16'd3,16'd4,16'd0,16'd0, 2,1,0,
              48'hC, 0,1, 48'hC};
    tv[1] = '{1,1, 2'd0,2'd1, 16'd1,16'd2,16'd7,16'd9, 1,1,0,
              48'h3F, 1,1, 48'h3F};
    tv[2] = '{1,1, 2'd2,2'd0, 16'hAA,16'hBB,16'h11,16'h22, 3,1,0,
              48'hABCD, 0,1, 48'hABCD};
    tv[3] = '{0,1, 2'd0,2'd3, 16'd0,16'd0,16'h55,16'h66, 2,1,0,
              48'h99, 1,0, 48'h0};
    tv[4] = '{1,1, 2'd0,2'd1, 16'h12,16'h34,16'h56,16'h78, 2,1,1,
              48'h1234, 0,0, 48'h0};
    tv[5] = '{0,1, 2'd0,2'd1, 16'd0,16'd0,16'h5,16'h6, 2,0,1,
              48'h55, 1,0, 48'h0};
    tv[6] = '{1,0, 2'd1,2'd0, 16'hFFFF,16'h1,16'd0,16'd0, 4,1,0,
              48'hFFFF_FFFF_FFFF, 0,1, 48'hFFFF_FFFF_FFFF};

    // reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_outs", 64'({ack0, ack1, done0, done1, err0, err1,
        busy, grant_id, timeout, alu_start, alu_a_valid,
        alu_b_valid}), 64'd0);
    chk("rst_result", 64'(rsp_result), 64'd0);
    chk("rst_alu_data", 64'({alu_operation, alu_m1, alu_m2}), 64'd0);
    rst_n = 1'b1;
    tick();

    // single request, exact cycle timing
    mdl_lat = 2; mdl_v = 1; mdl_e = 0; mdl_res = 48'hC;
    op0 = 2'd0; m1_0 = 16'h3; m2_0 = 16'h4;
    req0 = 1'b1;
    tick();
    chk("s_ack", 64'({ack1, ack0}), 64'd1);
    chk("s_start", 64'({alu_start, alu_a_valid, alu_b_valid}), 64'd7);
    chk("s_busy", 64'(busy), 64'd1);
    chk("s_m", 64'({alu_m1, alu_m2}), 64'h0003_0004);
    req0 = 1'b0;
    tick();
    chk("s_nodone_early", 64'({done0, alu_start}), 64'd1);
    tick();
    chk("s_done", 64'({done1, done0, err1, err0}), 64'b0100);
    chk("s_result", 64'(rsp_result), 64'hC);
    chk("s_start_drop", 64'(alu_start), 64'd0);
    tick();
    chk("s_after", 64'({busy, done0}), 64'd0);
    chk("s_hold", 64'(rsp_result), 64'hC);

    for (int i = 0; i < 7; i++) run_row(i, tv[i]);

    // held tie after reset: grants 0, 1, 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mdl_never = 0; mdl_v = 1; mdl_e = 0; mdl_lat = 2; mdl_mul = 1;
    op0 = 0; op1 = 0;
    m1_0 = 16'd5; m2_0 = 16'd6; m1_1 = 16'd7; m2_1 = 16'd9;
    req0 = 1; req1 = 1;
    for (int t = 0; t < 3; t++) begin
      wait_ack(k);
      chk($sformatf("tie%0d_ack", t), 64'({ack1, ack0}),
          (t == 1) ? 64'd2 : 64'd1);
      chk($sformatf("tie%0d_m1", t), 64'(alu_m1),
          (t == 1) ? 64'd7 : 64'd5);
      wait_rsp(k);
      chk($sformatf("tie%0d_done", t), 64'({done1, done0}),
          (t == 1) ? 64'd2 : 64'd1);
      chk($sformatf("tie%0d_res", t), 64'(rsp_result),
          (t == 1) ? 64'd63 : 64'd30);
    end
    req0 = 0; req1 = 0;
    mdl_mul = 0;
    tick(); tick();

    // unresponsive ALU
    mdl_never = 1;
    op0 = 2'd1; m1_0 = 16'h21; m2_0 = 16'h22;
    req0 = 1;
    k = 0;
`ifdef COMPLEX_ALU_SCHED_TIMEOUT_EN
    do begin tick(); k++; if (ack0) req0 = 0; end
    while (!(err0 | done0) && k < 30);
    chk("to_cycles", 64'(k), 64'd9);
    chk("to_pulse", 64'({timeout, err0, done0}), 64'b110);
    chk("to_result", 64'(rsp_result), 64'd0);
    tick();
    chk("to_after", 64'({timeout, alu_start, err0}), 64'd0);
    mdl_never = 0; mdl_res = 48'h777; mdl_lat = 2;
    m1_0 = 16'h2; m2_0 = 16'h3;
    tick();
    req0 = 1;
    wait_ack(k);
    req0 = 0;
    wait_rsp(k);
    chk("to_next_done", 64'({done0, err0}), 64'b10);
    chk("to_next_res", 64'(rsp_result), 64'h777);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack0) req0 = 0;
      k += int'(err0 | done0 | timeout);
    end
    chk("nto_no_resp", 64'(k), 64'd0);
    chk("nto_waiting", 64'({busy, alu_start}), 64'd3);
    rst_n = 0;
    tick();
    rst_n = 1;
    mdl_never = 0;
`endif
    tick();

    // reset during WAIT aborts the transaction
    mdl_never = 1;
    op0 = 2'd0; m1_0 = 16'h44; m2_0 = 16'h45;
    req0 = 1;
    wait_ack(k);
    req0 = 0;
    tick(); tick(); tick();
    chk("rw_inwait", 64'({busy, alu_start}), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_async", 64'({busy, alu_start, alu_a_valid, alu_b_valid,
        grant_id, ack0, ack1}), 64'd0);
    chk("rw_data", 64'({alu_m1, alu_m2}), 64'd0);
    k = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      k += int'(done0 | done1 | err0 | err1);
    end
    chk("rw_no_resp", 64'(k), 64'd0);
    rst_n = 1'b1;
    mdl_never = 0; mdl_res = 48'h5A; mdl_lat = 1;
    op1 = 2'd0;
    req0 = 1; req1 = 1;
    wait_ack(k);
    chk("rw_tie_client0", 64'({ack1, ack0}), 64'd1);
    req0 = 0; req1 = 0;
    wait_rsp(k);
    chk("rw_done", 64'({done1, done0}), 64'd1);
    chk("rw_res", 64'(rsp_result), 64'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
